// File: rtl/pwm_edge_logger.sv
// Multi-channel PWM transition logger.
// It timestamps level changes on the PWM inputs over a programmable window and
// queues INIT / EDGE / FINAL records in an on-chip FIFO, which drains over a
// valid/ready stream.
module pwm_edge_logger #(
    parameter int CHANNELS     = 4,
    parameter int TS_WIDTH     = 24,
    parameter int WINDOW_WIDTH = 24,
    parameter int DEPTH        = 16,
    parameter int SYNC_STAGES  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     pwm_in,
    input  logic [CHANNELS-1:0]     chan_en,
    input  logic [WINDOW_WIDTH-1:0] window_cycles,
    input  logic                    start,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [1:0]              evt_kind,
    output logic [CHANNELS-1:0]     evt_level,
    output logic [TS_WIDTH-1:0]     evt_ts,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int REC_W = 2 + CHANNELS + TS_WIDTH;

    localparam logic [1:0] KIND_INIT  = 2'd0;
    localparam logic [1:0] KIND_EDGE  = 2'd1;
    localparam logic [1:0] KIND_FINAL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_FINAL
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (pass-through when SYNC_STAGES is 0)
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pwm_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign pwm_s = pwm_in;
    end else begin : g_sync
        logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

        // Shift the raw PWM levels through the synchroniser chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so every
                // flop samples the pre-edge values of its neighbours.
                sync_q[0] <= pwm_in;
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end

        assign pwm_s = sync_q[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] window_q;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] en_q;
    logic                busy_q;
    logic                done_q;
    logic                overflow_q;
    logic [15:0]         drop_q;

    // FIFO storage and pointers (one extra pointer bit separates full from empty)
    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    logic [CHANNELS-1:0] lv;
    logic [CHANNELS-1:0] lv_start;
    logic [TS_WIDTH-1:0] ts_next;
    logic [TS_WIDTH-1:0] window_eff;
    logic [PTR_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                pop;
    logic                can_push;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [REC_W-1:0]    head;

    logic                push_req;
    logic                flush;
    logic [1:0]          push_kind;
    logic [CHANNELS-1:0] push_level;
    logic [TS_WIDTH-1:0] push_ts;

    // Disabled channels read as 0; the start edge uses the mask being latched.
    assign lv       = pwm_s & en_q;
    assign lv_start = pwm_s & chan_en;

    assign ts_next    = ts_q + TS_WIDTH'(1);
    assign window_eff = (window_cycles == '0) ? TS_WIDTH'(1) : TS_WIDTH'(window_cycles);

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == PTR_W'(DEPTH));
    assign evt_valid  = (fifo_count != '0);
    assign pop        = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign can_push   = !fifo_full || pop;

    // Choose which record (if any) this cycle wants to write.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        push_req   = 1'b0;
        flush      = 1'b0;
        push_kind  = KIND_EDGE;
        push_level = lv;
        push_ts    = ts_next;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    flush      = 1'b1;
                    push_req   = 1'b1;
                    push_kind  = KIND_INIT;
                    push_level = lv_start;
                    push_ts    = '0;
                end
            end
            S_CAPTURE: begin
                push_req = (lv != prev_q);
            end
            S_FINAL: begin
                push_req   = 1'b1;
                push_kind  = KIND_FINAL;
                push_level = prev_q;
                push_ts    = window_q;
            end
            default: ;
        endcase
    end

    // The flush empties the FIFO, so INIT always lands in slot 0.
    assign wr_en   = flush || (push_req && can_push);
    assign wr_addr = flush ? '0 : wr_ptr_q[AW-1:0];

    // Record storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers alone decide which
        // entries are meaningful, and the outputs are gated while empty.
        if (wr_en) mem_q[wr_addr] <= {push_kind, push_level, push_ts};
    end

    // FIFO pointers: a start flush resets them with INIT already written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= PTR_W'(1);
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            window_q   <= '0;
            prev_q     <= '0;
            en_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        en_q       <= chan_en;
                        prev_q     <= lv_start;
                        ts_q       <= '0;
                        window_q   <= window_eff;
                        overflow_q <= 1'b0;
                        drop_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    ts_q   <= ts_next;
                    prev_q <= lv;
                    if (push_req && !can_push) begin
                        overflow_q <= 1'b1;
                        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                    end
                    if (ts_next == window_q) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    // FINAL is never dropped: hold here until it fits.
                    if (can_push) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_kind   = evt_valid ? head[REC_W-1 -: 2]            : '0;
    assign evt_level  = evt_valid ? head[TS_WIDTH +: CHANNELS]    : '0;
    assign evt_ts     = evt_valid ? head[TS_WIDTH-1:0]            : '0;

    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/pwm_edge_logger.md
# pwm_edge_logger

Multi-channel, synthesizable PWM transition logger. It timestamps level changes on up to CHANNELS PWM outputs (raw mix, filtered mix, per-voice debug taps) over a programmable capture window. Each change becomes a record in an on-chip FIFO, drained over a valid/ready stream by the debug/readout path. Each capture is framed by an INIT record and a FINAL record, so a host can rebuild piecewise-linear waveforms for analog filter simulation without a simulator-side monitor.

## Interface
- CHANNELS, 4: number of PWM inputs (1..8)
- TS_WIDTH, 24: timestamp width in clk cycles; must be ≥ WINDOW_WIDTH
- WINDOW_WIDTH, 24: width of window_cycles
- DEPTH, 16: FIFO depth in records; power of two, ≥ 2
- SYNC_STAGES, 0: input synchroniser flops per channel (0, 1 or 2)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pwm_in  in  CHANNELS  PWM levels to observe
- chan_en  in  CHANNELS  channel enable mask; latched at start
- window_cycles  in  WINDOW_WIDTH  capture length in cycles; 0 is treated as 1
- start  in  1  capture request; acted on only in IDLE
- evt_valid  out  1  a FIFO head record is available
- evt_ready  in  1  consumer accepts the head record
- evt_kind  out  2  0=INIT, 1=EDGE, 2=FINAL
- evt_level  out  CHANNELS  masked channel levels after the event
- evt_ts  out  TS_WIDTH  cycles since start
- busy  out  1  high in CAPTURE or FINAL
- done  out  1  one-cycle pulse when the FINAL record is written
- overflow  out  1  sticky: at least one EDGE record was dropped
- drop_count  out  16  dropped EDGE records, saturating at 0xFFFF

## Operation
- Sampled signal: lv = sync(pwm_in) & en_q. en_q is chan_en latched at start. Disabled channels read 0 and never generate edges.
- State IDLE. On a clk edge with start=1:
  - Flush the FIFO.
  - Clear ts, overflow and drop_count.
  - Latch en_q; set prev to lv.
  - Write INIT{level=lv, ts=0}.
  - Go to CAPTURE.
  - The FIFO is empty after the flush, so INIT is never dropped.
- State CAPTURE, every edge:
  - ts ← ts+1.
  - If lv ≠ prev, push EDGE{level=lv, ts=ts+1}.
  - prev ← lv, whether the push succeeds or not.
  - When ts+1 = max(window_cycles,1), go to FINAL. The edge at that cycle is still recorded.
- Simultaneous changes on several channels produce one EDGE record carrying the full level vector.
- Push on a full FIFO:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the record is dropped, overflow is set and drop_count increments (saturating).
- State FINAL:
  - Push FINAL{level=prev, ts=window} as soon as it fits (same full/pop rule as above). FINAL is never dropped; the block stalls in FINAL until it fits.
  - On the successful push, done=1 for that cycle and the state goes to IDLE.
- start is ignored in CAPTURE and FINAL.
- window_cycles is sampled at start; later changes have no effect.
- The FIFO keeps draining in IDLE. Results remain readable until the next start.
- Timestamps cannot wrap because TS_WIDTH ≥ WINDOW_WIDTH.

## Timing
- Reset values:
  - State IDLE; busy, done, overflow, evt_valid = 0.
  - drop_count, evt_kind, evt_level, evt_ts = 0.
  - FIFO empty; synchroniser flops and prev = 0.
- A pwm_in change reaches lv after SYNC_STAGES cycles. The recorded ts includes that delay, which is constant for all channels.
- Write to visibility: a record written on edge k drives evt_valid=1 from after edge k.
- Stream handshake:
  - The head is popped on an edge with evt_valid & evt_ready.
  - evt_* are stable while evt_valid=1 and evt_ready=0.
- busy rises after the start edge and falls after the edge that writes FINAL.
- Minimum capture: window=1 gives INIT, then at most one EDGE, then FINAL with ts=1.
- rst_n low at any time, including mid-capture or mid-stall, forces the reset values immediately. Pending records are lost.

## Test plan
- CHANNELS=4, window=100, evt_ready=1; ch0 rises at ts 10, falls at 30 → INIT(0000,0), EDGE(0001,10), EDGE(0000,30), FINAL(0000,100); one done pulse; busy high for exactly 101 cycles.
- ch1 and ch3 rise on the same cycle (ts 5) → single EDGE(1010,5); no extra record.
- chan_en=0010; toggle ch0 and ch2 repeatedly → only INIT(0000,0) and FINAL(0000,window); overflow=0.
- DEPTH=4, evt_ready=0, 6 edges in window=50 → FIFO holds INIT plus 3 EDGEs; overflow=1, drop_count=3; block stalls in FINAL with busy=1. Raise evt_ready → FINAL(level,50) delivered 5th, then done.
- FIFO full in CAPTURE with an edge and evt_ready=1 on the same cycle → edge accepted; drop_count unchanged.
- start pulse during CAPTURE is ignored (no flush, ts continues). rst_n low at ts 40 → evt_valid=0, busy=0, overflow=0, drop_count=0 immediately. A fresh start afterwards yields INIT ts=0.
